// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: pixel coordinates, mode control and colour output between timing controller and pattern generator
interface vga_pattern_gen_if #(parameter int COLOR_W = 12);
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic pix_valid;
  logic [1:0] mode_sel;
  logic mode_wr;
  logic [COLOR_W-1:0] pix_data;
  logic [1:0] cur_mode;
  logic mode_busy;
  logic [15:0] frame_cnt;
  modport master (output pix_x, pix_y, pix_valid, mode_sel, mode_wr, input pix_data, cur_mode, mode_busy, frame_cnt);
  modport slave (input pix_x, pix_y, pix_valid, mode_sel, mode_wr, output pix_data, cur_mode, mode_busy, frame_cnt);
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: frame-synchronous VGA bar/checker/bouncing-box pattern source; define VGA_PAT_BOX_EN to build the box mode
module vga_pattern_gen #(
  parameter int H_VALID = 640,
  parameter int V_VALID = 480,
  parameter int COLOR_W = 12,
  parameter int CHK_LOG2 = 5,
  parameter int BOX_SIZE = 32
) (
  input logic vga_clk,
  input logic sys_rst,
  vga_pattern_gen_if.slave vif
);
  localparam int CW = COLOR_W / 3;
  localparam logic [CW-1:0] F = '1;
  localparam logic [CW-1:0] H = {1'b1, {(CW-1){1'b0}}};
  localparam logic [CW-1:0] Z = '0;
  localparam logic [COLOR_W-1:0] WHITE = {F, F, F};
  localparam logic [COLOR_W-1:0] BARS [8] = '{{F, Z, Z}, {F, H, Z}, {F, F, Z}, {Z, F, Z},
                                              {Z, F, F}, {Z, Z, F}, {F, Z, F}, {F, F, F}};
  function automatic logic [2:0] band(input logic [9:0] c, input int span);
    logic [2:0] b;
    b = '0;
    for (int k = 1; k < 8; k++)
      if ({22'd0, c} >= 32'(k * span / 8)) b = b + 3'd1;
    return b;
  endfunction
  logic [COLOR_W-1:0] pix_data, pat, pix_nxt;
  logic [1:0] cur_mode, pend;
  logic mode_busy, in_area, fe, wr_ok, in_box;
  logic [15:0] frame_cnt;
  assign in_area = vif.pix_valid && {1'b0, vif.pix_x} < 11'(H_VALID) && {1'b0, vif.pix_y} < 11'(V_VALID);
  assign fe = in_area && vif.pix_x == 10'(H_VALID - 1) && vif.pix_y == 10'(V_VALID - 1);
`ifdef VGA_PAT_BOX_EN
  logic [9:0] box_x, box_y;
  logic dx_neg, dy_neg, flip_x, flip_y;
  assign wr_ok = vif.mode_wr;
  assign in_box = vif.pix_x >= box_x && {1'b0, vif.pix_x} < {1'b0, box_x} + 11'(BOX_SIZE) &&
                  vif.pix_y >= box_y && {1'b0, vif.pix_y} < {1'b0, box_y} + 11'(BOX_SIZE);
  assign flip_x = dx_neg ? box_x == '0 : {1'b0, box_x} + 11'(BOX_SIZE) == 11'(H_VALID);
  assign flip_y = dy_neg ? box_y == '0 : {1'b0, box_y} + 11'(BOX_SIZE) == 11'(V_VALID);
  // Reversing direction and stepping in the same frame keeps the box strictly inside the active area
  always_ff @(posedge vga_clk)
    if (sys_rst) begin
      box_x <= '0;
      box_y <= '0;
      dx_neg <= 1'b0;
      dy_neg <= 1'b0;
    end else if (fe) begin
      dx_neg <= dx_neg ^ flip_x;
      dy_neg <= dy_neg ^ flip_y;
      box_x <= (dx_neg ^ flip_x) ? box_x - 10'd1 : box_x + 10'd1;
      box_y <= (dy_neg ^ flip_y) ? box_y - 10'd1 : box_y + 10'd1;
    end
`else
  assign wr_ok = vif.mode_wr && vif.mode_sel != 2'd3;
  assign in_box = 1'b0;
`endif
  always_comb begin
    pat = cur_mode == 2'd0 ? BARS[band(vif.pix_x, H_VALID)] :
          cur_mode == 2'd1 ? BARS[band(vif.pix_y, V_VALID)] :
          cur_mode == 2'd2 ? ((vif.pix_x[CHK_LOG2] ^ vif.pix_y[CHK_LOG2]) ? WHITE : '0) :
          (in_box ? WHITE : '0);
    pix_nxt = in_area ? pat : '0;
  end
  // A write landing on the frame-end cycle takes effect at that same boundary
  always_ff @(posedge vga_clk)
    if (sys_rst) begin
      pix_data <= '0;
      cur_mode <= '0;
      pend <= '0;
      mode_busy <= 1'b0;
      frame_cnt <= '0;
    end else begin
      pix_data <= pix_nxt;
      if (fe) begin
        cur_mode <= wr_ok ? vif.mode_sel : mode_busy ? pend : cur_mode;
        mode_busy <= 1'b0;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (wr_ok) begin
        pend <= vif.mode_sel;
        mode_busy <= 1'b1;
      end
    end
  assign vif.pix_data = pix_data;
  assign vif.cur_mode = cur_mode;
  assign vif.mode_busy = mode_busy;
  assign vif.frame_cnt = frame_cnt;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed self-checking bench for vga_pattern_gen (box checks follow VGA_PAT_BOX_EN)
module tb_vga_pattern_gen;
  logic vga_clk = 1'b0;
  logic sys_rst = 1'b1;
  int checks = 0;
  int errors = 0;
  vga_pattern_gen_if #(.COLOR_W(12)) vif ();
  vga_pattern_gen #(.H_VALID(640), .V_VALID(480), .COLOR_W(12), .CHK_LOG2(5), .BOX_SIZE(32)) dut (
    .vga_clk(vga_clk),
    .sys_rst(sys_rst),
    .vif(vif.slave)
  );
  always #5 vga_clk = ~vga_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int x, input int y, input logic v, input logic wr = 1'b0, input logic [1:0] sel = 2'd0);
    vif.pix_x = 10'(x);
    vif.pix_y = 10'(y);
    vif.pix_valid = v;
    vif.mode_wr = wr;
    vif.mode_sel = sel;
    @(posedge vga_clk);
    #1;
    vif.mode_wr = 1'b0;
  endtask
  task automatic fe(input logic wr = 1'b0, input logic [1:0] sel = 2'd0);
    step(639, 479, 1'b1, wr, sel);
  endtask
  task automatic px(input int x, input int y, input logic [11:0] exp, input string tag);
    step(x, y, 1'b1);
    check($sformatf("%s(%0d,%0d)", tag, x, y), 32'(vif.pix_data), 32'(exp));
  endtask
  int xs [11] = '{0, 79, 80, 160, 240, 320, 400, 479, 480, 560, 639};
  logic [11:0] xe [11] = '{12'hF00, 12'hF00, 12'hF80, 12'hFF0, 12'h0F0, 12'h0FF, 12'h00F, 12'h00F, 12'hF0F, 12'hFFF, 12'hFFF};
  int ys [6] = '{0, 59, 60, 180, 360, 478};
  logic [11:0] ye [6] = '{12'hF00, 12'hF00, 12'hF80, 12'h0F0, 12'hF0F, 12'hFFF};
  initial begin
    vif.pix_x = '0;
    vif.pix_y = '0;
    vif.pix_valid = 1'b0;
    vif.mode_wr = 1'b0;
    vif.mode_sel = '0;
    repeat (2) @(posedge vga_clk);
    #1;
    check("rst_pix", 32'(vif.pix_data), 0);
    check("rst_mode", 32'(vif.cur_mode), 0);
    check("rst_busy", 32'(vif.mode_busy), 0);
    check("rst_frame", 32'(vif.frame_cnt), 0);
    sys_rst = 1'b0;
    for (int i = 0; i < 11; i++) px(xs[i], 0, xe[i], "vbar");
    step(100, 0, 1'b0);
    check("blank", 32'(vif.pix_data), 0);
    px(700, 0, 12'h000, "oob_x");
    px(639, 500, 12'h000, "oob_y");
    check("no_fe", 32'(vif.frame_cnt), 0);
    step(10, 10, 1'b1, 1'b1, 2'd2);
    check("wr_busy", 32'(vif.mode_busy), 1);
    check("wr_mode", 32'(vif.cur_mode), 0);
    check("wr_pix", 32'(vif.pix_data), 32'h0F00);
    px(32, 0, 12'hF00, "old_mode");
    check("still_busy", 32'(vif.mode_busy), 1);
    fe();
    check("fe_pix", 32'(vif.pix_data), 32'h0FFF);
    check("fe_mode", 32'(vif.cur_mode), 2);
    check("fe_busy", 32'(vif.mode_busy), 0);
    check("fe_frame", 32'(vif.frame_cnt), 1);
    px(32, 0, 12'hFFF, "chk");
    px(32, 32, 12'h000, "chk");
    px(0, 32, 12'hFFF, "chk");
    px(0, 0, 12'h000, "chk");
    fe(1'b1, 2'd1);
    check("fewr_mode", 32'(vif.cur_mode), 1);
    check("fewr_busy", 32'(vif.mode_busy), 0);
    check("fewr_frame", 32'(vif.frame_cnt), 2);
    for (int i = 0; i < 6; i++) px(0, ys[i], ye[i], "hbar");
    step(5, 5, 1'b1, 1'b1, 2'd0);
    step(6, 5, 1'b1, 1'b1, 2'd2);
    check("two_busy", 32'(vif.mode_busy), 1);
    check("two_mode_pre", 32'(vif.cur_mode), 1);
    fe();
    check("two_mode", 32'(vif.cur_mode), 2);
    check("two_frame", 32'(vif.frame_cnt), 3);
    step(5, 5, 1'b1, 1'b1, 2'd0);
    fe(1'b1, 2'd1);
    check("fe_over_pend", 32'(vif.cur_mode), 1);
    check("fe_over_busy", 32'(vif.mode_busy), 0);
    step(5, 5, 1'b1, 1'b1, 2'd2);
    sys_rst = 1'b1;
    step(100, 5, 1'b1);
    check("mrst_pix", 32'(vif.pix_data), 0);
    check("mrst_mode", 32'(vif.cur_mode), 0);
    check("mrst_busy", 32'(vif.mode_busy), 0);
    check("mrst_frame", 32'(vif.frame_cnt), 0);
    sys_rst = 1'b0;
    fe();
    check("pend_discard", 32'(vif.cur_mode), 0);
    check("post_rst_frame", 32'(vif.frame_cnt), 1);
`ifdef VGA_PAT_BOX_EN
    sys_rst = 1'b1;
    step(0, 0, 1'b0);
    sys_rst = 1'b0;
    step(0, 0, 1'b0, 1'b1, 2'd3);
    fe();
    check("box_mode", 32'(vif.cur_mode), 3);
    px(1, 1, 12'hFFF, "box1");
    px(0, 0, 12'h000, "box1");
    px(32, 32, 12'hFFF, "box1");
    px(33, 1, 12'h000, "box1");
    repeat (447) fe();
    px(448, 448, 12'hFFF, "box448");
    px(447, 448, 12'h000, "box448");
    px(479, 478, 12'hFFF, "box448");
    fe();
    px(449, 447, 12'hFFF, "box449");
    px(449, 446, 12'h000, "box449");
    px(480, 478, 12'hFFF, "box449");
    px(481, 478, 12'h000, "box449");
    repeat (159) fe();
    px(608, 288, 12'hFFF, "box608");
    px(607, 288, 12'h000, "box608");
    px(639, 319, 12'hFFF, "box608");
    px(639, 320, 12'h000, "box608");
    fe();
    px(607, 287, 12'hFFF, "box609");
    px(639, 287, 12'h000, "box609");
    px(638, 318, 12'hFFF, "box609");
    check("box_frame", 32'(vif.frame_cnt), 609);
`else
    step(1, 1, 1'b1, 1'b1, 2'd3);
    check("m3_busy", 32'(vif.mode_busy), 0);
    fe(1'b1, 2'd3);
    check("m3_fe_mode", 32'(vif.cur_mode), 0);
    step(1, 1, 1'b1, 1'b1, 2'd2);
    step(1, 1, 1'b1, 1'b1, 2'd3);
    check("m3_pend_busy", 32'(vif.mode_busy), 1);
    fe();
    check("m3_pend_mode", 32'(vif.cur_mode), 2);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
